// File: rtl/sync_fifo_test_pkg.sv
// Shared encodings for the FIFO exerciser: FSM states, UART command and response bytes,
// and the LFSR tap table.
package sync_fifo_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WRITE, ST_W_SETTLE, ST_READ, ST_TX_HOLD, ST_VERIFY, ST_V_SETTLE, ST_REPORT
   } state_t;

   localparam logic [7:0] CMD_W  = 8'h77;
   localparam logic [7:0] CMD_L  = 8'h6C;
   localparam logic [7:0] CMD_R  = 8'h72;
   localparam logic [7:0] CMD_V  = 8'h76;
   localparam logic [7:0] CMD_S  = 8'h73;
   localparam logic [7:0] CMD_X  = 8'h78;
   localparam logic [7:0] RESP_P = 8'h50;
   localparam logic [7:0] RESP_F = 8'h46;

   // Fibonacci tap masks. Bit i set means stage i feeds the XOR.
   // Width 8 is x^8+x^6+x^5+x^4+1.
   function automatic logic [31:0] lfsr_taps(input int width);
      case (width)
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         16:      return 32'h0000_B400;
         default: return 32'h0000_0003 << (width - 2);
      endcase
   endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Left-shifting Fibonacci LFSR. The load input and the reset input both reload SEED.
module lfsr_gen
   import sync_fifo_test_pkg::*;
#(
   parameter int                   DATA_BITS = 8,
   parameter logic [DATA_BITS-1:0] SEED      = 'h01
) (
   input  logic                 clk_in,
   input  logic                 n_rst,
   input  logic                 load,
   input  logic                 step,
   output logic [DATA_BITS-1:0] q
);

   localparam logic [DATA_BITS-1:0] TAPS = DATA_BITS'(lfsr_taps(DATA_BITS));

   logic fb;
   assign fb = ^(q & TAPS);

   always_ff @(posedge clk_in) begin
      if (!n_rst || load) q <= SEED;
      else if (step)      q <= {q[DATA_BITS-2:0], fb};
   end

endmodule

// File: rtl/sync_fifo_test_ctrl.sv
// UART-command-driven exerciser for a synchronous FIFO: write bursts, drain to UART,
// ramp verification and fill-level report.
module sync_fifo_test_ctrl
   import sync_fifo_test_pkg::*;
#(
   parameter int                   DATA_BITS  = 8,
   parameter int                   LEVEL_BITS = 9,
   parameter int                   BURST_LEN  = 256,
   parameter int                   CNT_BITS   = 10,
   parameter logic [DATA_BITS-1:0] LFSR_SEED  = 'h01
) (
   input  logic                  clk_in,
   input  logic                  n_rst,
   input  logic                  uart_rx_valid_in,
   input  logic [DATA_BITS-1:0]  uart_rx_data_in,
   input  logic                  uart_tx_ready_in,
   input  logic                  fifo_full_in,
   input  logic                  fifo_empty_in,
   input  logic [LEVEL_BITS-1:0] fifo_level_in,
   input  logic [DATA_BITS-1:0]  fifo_rd_data_in,
   output logic                  fifo_wr_en,
   output logic [DATA_BITS-1:0]  fifo_wr_data_out,
   output logic                  fifo_rd_en,
   output logic                  uart_tx_en,
   output logic [DATA_BITS-1:0]  uart_tx_data_out,
   output logic                  busy_out,
   output logic                  done_out,
   output logic [CNT_BITS-1:0]   err_count_out
);

   localparam logic [DATA_BITS-1:0] C_W = DATA_BITS'(CMD_W);
   localparam logic [DATA_BITS-1:0] C_L = DATA_BITS'(CMD_L);
   localparam logic [DATA_BITS-1:0] C_R = DATA_BITS'(CMD_R);
   localparam logic [DATA_BITS-1:0] C_V = DATA_BITS'(CMD_V);
   localparam logic [DATA_BITS-1:0] C_S = DATA_BITS'(CMD_S);
   localparam logic [DATA_BITS-1:0] C_X = DATA_BITS'(CMD_X);
   localparam logic [CNT_BITS-1:0]  BURST_N = CNT_BITS'(BURST_LEN);
   localparam logic [31:0]          LVL_MAX = (32'd1 << DATA_BITS) - 32'd1;

   state_t                state, state_n;
   logic [CNT_BITS-1:0]   count, count_n, expect_q, expect_n, err_n;
   logic                  mode_lfsr, mode_n;
   logic [DATA_BITS-1:0]  rpt, rpt_n, lvl_sat, lfsr_q;
   logic                  wr_en_n, rd_en_n, tx_en_n, done_n, lfsr_load, lfsr_step, abort;
   logic [DATA_BITS-1:0]  wr_data_n, tx_data_n;

   lfsr_gen #(.DATA_BITS(DATA_BITS), .SEED(LFSR_SEED)) u_lfsr (
      .clk_in (clk_in),
      .n_rst  (n_rst),
      .load   (lfsr_load),
      .step   (lfsr_step),
      .q      (lfsr_q)
   );

   assign lvl_sat = (32'(fifo_level_in) > LVL_MAX) ? '1 : DATA_BITS'(fifo_level_in);
   assign abort   = uart_rx_valid_in && (uart_rx_data_in == C_X);

   always_comb begin
      state_n   = state;
      count_n   = count;
      expect_n  = expect_q;
      err_n     = err_count_out;
      mode_n    = mode_lfsr;
      rpt_n     = rpt;
      wr_en_n   = 1'b0;
      wr_data_n = fifo_wr_data_out;
      rd_en_n   = 1'b0;
      tx_en_n   = 1'b0;
      tx_data_n = uart_tx_data_out;
      done_n    = 1'b0;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      case (state)
         ST_IDLE: if (uart_rx_valid_in) begin
            case (uart_rx_data_in)
               C_W: begin state_n = ST_WRITE; count_n = '0; mode_n = 1'b0; end
               // Each 'l' burst restarts the sequence so bursts are reproducible.
               C_L: begin state_n = ST_WRITE; count_n = '0; mode_n = 1'b1; lfsr_load = 1'b1; end
               C_R: state_n = ST_READ;
               C_V: begin state_n = ST_VERIFY; err_n = '0; expect_n = '0; end
               C_S: begin state_n = ST_REPORT; rpt_n = lvl_sat; end
               default: ;
            endcase
         end
         ST_WRITE: begin
            if (count == BURST_N || fifo_full_in) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end else begin
               wr_en_n   = 1'b1;
               wr_data_n = mode_lfsr ? lfsr_q : DATA_BITS'(count);
               lfsr_step = mode_lfsr;
               count_n   = count + 1'b1;
               state_n   = ST_W_SETTLE;
            end
         end
         ST_W_SETTLE: state_n = ST_WRITE;
         ST_READ: begin
            if (!fifo_empty_in && uart_tx_ready_in) begin
               rd_en_n   = 1'b1;
               tx_en_n   = 1'b1;
               tx_data_n = fifo_rd_data_in;
               state_n   = ST_TX_HOLD;
            end else if (fifo_empty_in) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end
         end
         // The transmitter drops ready one cycle late, so ready is ignored here.
         ST_TX_HOLD: state_n = ST_READ;
         ST_VERIFY: begin
            if (!fifo_empty_in) begin
               rd_en_n  = 1'b1;
               if (fifo_rd_data_in != DATA_BITS'(expect_q) && err_count_out != '1)
                  err_n = err_count_out + 1'b1;
               expect_n = expect_q + 1'b1;
               state_n  = ST_V_SETTLE;
            end else begin
               rpt_n   = (err_count_out == '0) ? DATA_BITS'(RESP_P) : DATA_BITS'(RESP_F);
               state_n = ST_REPORT;
            end
         end
         ST_V_SETTLE: state_n = ST_VERIFY;
         ST_REPORT: if (uart_tx_ready_in) begin
            tx_en_n   = 1'b1;
            tx_data_n = rpt;
            state_n   = ST_IDLE;
            done_n    = 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase
      // Abort cancels whatever this cycle would have issued. It only reports done when leaving a command.
      if (abort && state != ST_IDLE) begin
         state_n   = ST_IDLE;
         wr_en_n   = 1'b0;
         rd_en_n   = 1'b0;
         tx_en_n   = 1'b0;
         wr_data_n = fifo_wr_data_out;
         tx_data_n = uart_tx_data_out;
         err_n     = err_count_out;
         lfsr_step = 1'b0;
         done_n    = 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!n_rst) begin
         state            <= ST_IDLE;
         count            <= '0;
         expect_q         <= '0;
         mode_lfsr        <= 1'b0;
         rpt              <= '0;
         fifo_wr_en       <= 1'b0;
         fifo_wr_data_out <= '0;
         fifo_rd_en       <= 1'b0;
         uart_tx_en       <= 1'b0;
         uart_tx_data_out <= '0;
         busy_out         <= 1'b0;
         done_out         <= 1'b0;
         err_count_out    <= '0;
      end else begin
         state            <= state_n;
         count            <= count_n;
         expect_q         <= expect_n;
         mode_lfsr        <= mode_n;
         rpt              <= rpt_n;
         fifo_wr_en       <= wr_en_n;
         fifo_wr_data_out <= wr_data_n;
         fifo_rd_en       <= rd_en_n;
         uart_tx_en       <= tx_en_n;
         uart_tx_data_out <= tx_data_n;
         busy_out         <= (state_n != ST_IDLE);
         done_out         <= done_n;
         err_count_out    <= err_n;
      end
   end

endmodule

// File: tb/tb_sync_fifo_test_ctrl.sv
// Bench for sync_fifo_test_ctrl: queue FIFO model, UART transmitter model, scoreboards for
// FIFO writes and UART bytes.
module tb_sync_fifo_test_ctrl;

   localparam int DB = 8;
   localparam int LB = 9;
   localparam int BL = 32;
   localparam int CB = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          n_rst, rx_valid;
   logic [DB-1:0] rx_data;
   logic          tx_ready;
   logic          f_full = 1'b0, f_empty = 1'b1;
   logic [LB-1:0] f_level = '0;
   logic [DB-1:0] f_head = '0;
   logic          wr_en, rd_en, tx_en, busy, done;
   logic [DB-1:0] wr_data, tx_data;
   logic [CB-1:0] err_cnt;

   sync_fifo_test_ctrl #(
      .DATA_BITS(DB), .LEVEL_BITS(LB), .BURST_LEN(BL), .CNT_BITS(CB), .LFSR_SEED(8'h01)
   ) dut (
      .clk_in           (clk),
      .n_rst            (n_rst),
      .uart_rx_valid_in (rx_valid),
      .uart_rx_data_in  (rx_data),
      .uart_tx_ready_in (tx_ready),
      .fifo_full_in     (f_full),
      .fifo_empty_in    (f_empty),
      .fifo_level_in    (f_level),
      .fifo_rd_data_in  (f_head),
      .fifo_wr_en       (wr_en),
      .fifo_wr_data_out (wr_data),
      .fifo_rd_en       (rd_en),
      .uart_tx_en       (tx_en),
      .uart_tx_data_out (tx_data),
      .busy_out         (busy),
      .done_out         (done),
      .err_count_out    (err_cnt)
   );

   int          depth = 16;
   logic [7:0]  fq[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  exp_wr[$];
   int          busy_len = 2;
   int          tx_busy = 0;
   logic        ready_gate = 1'b1;
   int          n_chk = 0, n_pass = 0;
   int          n_wr = 0, n_tx = 0, cyc = 0, last_wr = -1;

   assign tx_ready = (tx_busy == 0) && ready_gate;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   // First-word fall-through FIFO whose flags update at the clock edge.
   always @(posedge clk) begin
      if (rd_en && fq.size() > 0) void'(fq.pop_front());
      if (wr_en && fq.size() < depth) fq.push_back(wr_data);
      f_level <= LB'(fq.size());
      f_full  <= (fq.size() >= depth);
      f_empty <= (fq.size() == 0);
      f_head  <= (fq.size() > 0) ? fq[0] : 8'h00;
   end

   always @(posedge clk) begin
      if (tx_en)            tx_busy <= busy_len;
      else if (tx_busy > 0) tx_busy <= tx_busy - 1;
   end

   always @(negedge clk) begin
      cyc++;
      if (wr_en) begin
         n_wr++;
         if (last_wr >= 0) chk("wr_gap", 32'(cyc - last_wr), 32'd2);
         last_wr = cyc;
         if (exp_wr.size() == 0) chk("wr_unexpected", 32'(exp_wr.size()), 32'd1);
         else chk("wr_data", 32'(wr_data), 32'(exp_wr.pop_front()));
      end
      if (rd_en) chk("rd_while_empty", 32'(f_empty), 32'd0);
      if (tx_en) begin
         n_tx++;
         if (exp_tx.size() == 0) chk("tx_unexpected", 32'(exp_tx.size()), 32'd1);
         else chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < max; k++) begin
         @(posedge clk);
         #1;
         if (done) begin seen = 1'b1; break; end
      end
      chk(tag, 32'(seen), 32'd1);
      tick(1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wr_en"},   32'(wr_en),   32'd0);
      chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
      chk({tag, "_rd_en"},   32'(rd_en),   32'd0);
      chk({tag, "_tx_en"},   32'(tx_en),   32'd0);
      chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      chk({tag, "_busy"},    32'(busy),    32'd0);
      chk({tag, "_done"},    32'(done),    32'd0);
      chk({tag, "_err"},     32'(err_cnt), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s;
      int         errs, lvl, w0;

      n_rst = 1'b0; rx_valid = 1'b0; rx_data = '0;
      tick(3);
      chk_zero("reset");
      n_rst = 1'b1;
      tick(2);

      // Incrementing burst into a 16-deep FIFO stops on full
      for (int i = 0; i < 16; i++) exp_wr.push_back(8'(i));
      last_wr = -1; n_wr = 0;
      send("w");
      chk("w16_busy_on", 32'(busy), 32'd1);
      wait_done("w16_done", 200);
      chk("w16_level", 32'(f_level), 32'd16);
      chk("w16_count", 32'(n_wr), 32'd16);
      chk("w16_wrq_empty", 32'(exp_wr.size()), 32'd0);
      chk("w16_busy_off", 32'(busy), 32'd0);
      chk("w16_done_pulse", 32'(done), 32'd0);

      // Burst stops at BURST_LEN, then verify passes
      fq.delete(); depth = 64; tick(2);
      for (int i = 0; i < BL; i++) exp_wr.push_back(8'(i));
      last_wr = -1; n_wr = 0;
      send("w");
      wait_done("w32_done", 400);
      chk("w32_level", 32'(f_level), 32'(BL));
      chk("w32_count", 32'(n_wr), 32'(BL));
      exp_tx.push_back(8'h50);
      send("v");
      wait_done("v_pass_done", 400);
      chk("v_pass_err", 32'(err_cnt), 32'd0);
      chk("v_pass_level", 32'(f_level), 32'd0);
      chk("v_pass_txq", 32'(exp_tx.size()), 32'd0);

      // LFSR burst then verify fails
      fq.delete(); tick(2);
      s = 8'h01; errs = 0;
      for (int i = 0; i < BL; i++) begin
         exp_wr.push_back(s);
         if (s != 8'(i)) errs++;
         s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      end
      last_wr = -1;
      send("l");
      wait_done("l_done", 400);
      chk("l_level", 32'(f_level), 32'(BL));
      chk("l_wrq_empty", 32'(exp_wr.size()), 32'd0);
      exp_tx.push_back(8'h46);
      send("v");
      wait_done("v_fail_done", 400);
      chk("v_fail_err", 32'(err_cnt), 32'(errs));
      chk("v_fail_txq", 32'(exp_tx.size()), 32'd0);

      // Drain three words with the transmitter ready toggling
      fq.delete();
      fq.push_back(8'hA5); fq.push_back(8'h3C); fq.push_back(8'h7E);
      exp_tx.push_back(8'hA5); exp_tx.push_back(8'h3C); exp_tx.push_back(8'h7E);
      busy_len = 3; n_tx = 0;
      tick(2);
      send("r");
      tick(2);
      ready_gate = 1'b0;
      tick(6);
      ready_gate = 1'b1;
      wait_done("r3_done", 200);
      chk("r3_count", 32'(n_tx), 32'd3);
      chk("r3_txq", 32'(exp_tx.size()), 32'd0);
      chk("r3_level", 32'(f_level), 32'd0);

      // Abort mid-burst, then status reports the real level
      fq.delete(); depth = 256; tick(2);
      for (int i = 0; i < BL; i++) exp_wr.push_back(8'(i));
      last_wr = -1;
      send("w");
      for (int k = 0; k < 200; k++) begin
         if (f_level >= 10) break;
         tick(1);
      end
      chk("x_reached", 32'(f_level >= 10), 32'd1);
      send("x");
      chk("x_idle", 32'(busy), 32'd0);
      chk("x_done", 32'(done), 32'd1);
      w0 = n_wr;
      tick(20);
      exp_wr.delete();
      chk("x_no_wr", 32'(n_wr), 32'(w0));
      lvl = fq.size();
      chk("x_partial", 32'(lvl < BL), 32'd1);
      for (int i = 0; i < lvl; i++) chk("x_content", 32'(fq[i]), 32'(i));
      exp_tx.push_back(8'(lvl));
      send("s");
      wait_done("s_done", 100);
      chk("s_txq", 32'(exp_tx.size()), 32'd0);

      // Reset during a drain of 300 words, then status saturates
      fq.delete(); depth = 511;
      for (int i = 0; i < 300; i++) begin
         fq.push_back(8'(i));
         exp_tx.push_back(8'(i));
      end
      busy_len = 4;
      tick(2);
      send("r");
      tick(30);
      n_rst = 1'b0;
      tick(1);
      chk_zero("rst_mid");
      n_rst = 1'b1;
      exp_tx.delete();
      tick(2);
      chk("rst_level_kept", 32'(f_level > 255), 32'd1);
      exp_tx.push_back(8'hFF);
      send("s");
      wait_done("s_sat_done", 100);
      chk("s_sat_txq", 32'(exp_tx.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
